// File: rtl/riscv_pkg.sv
// Shared constants and the boot-loader state encoding for the instruction memory.
package riscv_pkg;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction store: one synchronous write port, one asynchronous read port.
// Zero-latency read; no flow control; contents are never reset.
module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader plus instruction memory: packs a byte stream into 32-bit words, then releases the core.
// Fetch is combinational; in_ready is high exactly while loading, so the stream stalls otherwise.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic [$clog2(DEPTH):0]     load_len,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      rom_addr,
  output logic [31:0]                instr,
  output logic                       core_rst_n,
  output logic                       load_done,
  output logic                       load_err,
  output logic [31:0]                checksum
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  LEN_ONE = (AW+1)'(1);
  localparam logic [AW:0]  LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  ldr_state_t    state;
  logic [AW:0]   len_q;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    byte_idx;
  logic [23:0]   lanes;

  logic          accept;
  logic          word_wr;
  logic          last_word;
  logic          len_ok;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic          fetch_ok;

  assign in_ready  = (state == LOAD);
  assign accept    = in_valid & in_ready;
  assign word_wr   = accept & (byte_idx == 2'd3);
  assign wr_word   = {in_data, lanes};
  assign last_word = ({1'b0, wr_ptr} == (len_q - LEN_ONE));
  assign len_ok    = (load_len != '0) && (load_len <= LEN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      wr_ptr     <= '0;
      byte_idx   <= '0;
      lanes      <= '0;
      checksum   <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      // The core comes out of reset one edge after the final word is in memory.
      core_rst_n <= (state == DONE);
      load_done  <= (state == DONE);

      case (state)
        IDLE: begin
          if (load_start) begin
            if (len_ok) begin
              state    <= LOAD;
              len_q    <= load_len;
              wr_ptr   <= '0;
              byte_idx <= '0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    lanes[7:0]   <= in_data;
              2'd1:    lanes[15:8]  <= in_data;
              2'd2:    lanes[23:16] <= in_data;
              default: ;
            endcase
            if (word_wr) begin
              wr_ptr   <= wr_ptr + PTR_ONE;
              checksum <= checksum + wr_word;
              if (last_word) begin
                state <= DONE;
              end
            end
          end
        end

        DONE: ;

        ERR: begin
          load_err <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (word_wr),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rom_addr[AW+1:2]),
    .rdata (rd_word)
  );

  // Misaligned, out-of-range and pre-release fetches all see a NOP.
  assign fetch_ok = (state == DONE) &&
                    (rom_addr[1:0] == 2'b00) &&
                    (rom_addr[DATA_WIDTH-1:AW+2] == '0);
  assign instr    = fetch_ok ? rd_word : NOP_INSTR;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, stall, fetch, error, mid-load reset and full-depth cases.
module tb_imem_loader;

  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [DW-1:0] rom_addr;
  logic [31:0]   instr;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;
  logic [31:0]   checksum;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [7:0]  prog [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  logic [31:0] sum_model;
  logic [31:0] w;

  imem_loader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rom_addr   (rom_addr),
    .instr      (instr),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [63:0] addr, input logic [31:0] exp);
    rom_addr = addr;
    #1;
    chk(tag, {32'h0, instr}, {32'h0, exp});
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    rom_addr   = '0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic start(input logic [AW:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick;
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset;
    chk("rst_in_ready",   in_ready,   1'b0);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_load_done",  load_done,  1'b0);
    chk("rst_load_err",   load_err,   1'b0);
    chk("rst_checksum",   checksum,   32'h0);
    fetch("rst_fetch0", 64'd0, NOP);

    // Two-word load, back-to-back bytes
    start(11'd2);
    chk("t1_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(prog[i]);
      if (i == 3) fetch("t1_fetch_pre_done", 64'd0, NOP);
    end
    chk("t1_done_not_yet", load_done,  1'b0);
    chk("t1_core_held",    core_rst_n, 1'b0);
    chk("t1_ready_off",    in_ready,   1'b0);
    chk("t1_checksum",     checksum,   32'h0030_0AA6);
    tick;
    chk("t1_load_done", load_done,  1'b1);
    chk("t1_core_run",  core_rst_n, 1'b1);
    fetch("t3_addr0",    64'd0,           32'h0010_0513);
    fetch("t3_addr4",    64'd4,           32'h0020_0593);
    fetch("t3_addr2",    64'd2,           NOP);
    fetch("t3_addr_oor", 64'd4 * DEPTH,   NOP);
    fetch("t3_addr_hi",  64'h1_0000_0000, NOP);

    // load_start and bytes offered after DONE
    load_start = 1'b1;
    load_len   = 11'd1;
    in_valid   = 1'b1;
    in_data    = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t6_done_ready", in_ready, 1'b0);
    end
    load_start = 1'b0;
    in_valid   = 1'b0;
    chk("t6_done_stays",  load_done, 1'b1);
    chk("t6_done_no_err", load_err,  1'b0);
    chk("t6_done_sum",    checksum,  32'h0030_0AA6);
    fetch("t6_done_mem0", 64'd0, 32'h0010_0513);
    fetch("t6_done_mem1", 64'd4, 32'h0020_0593);

    // Same load with a one-cycle gap after every byte; load_start pulsed mid-load
    do_reset;
    chk("t2_rst_checksum", checksum, 32'h0);
    start(11'd2);
    for (int i = 0; i < 8; i++) begin
      chk("t2_ready_byte", in_ready, 1'b1);
      send(prog[i]);
      if (i < 7) begin
        chk("t2_ready_gap", in_ready, 1'b1);
        if (i == 3) begin
          load_start = 1'b1;
          load_len   = 11'd0;
        end
        tick;
        load_start = 1'b0;
      end
    end
    chk("t2_checksum", checksum, 32'h0030_0AA6);
    chk("t2_no_err",   load_err, 1'b0);
    tick;
    chk("t2_load_done", load_done, 1'b1);
    fetch("t2_addr0", 64'd0, 32'h0010_0513);
    fetch("t2_addr4", 64'd4, 32'h0020_0593);

    // Illegal length 0
    do_reset;
    start(11'd0);
    chk("t4a_err",   load_err, 1'b1);
    chk("t4a_ready", in_ready, 1'b0);
    for (int i = 0; i < 100; i++) begin
      in_valid   = 1'($urandom_range(1, 0));
      in_data    = 8'($urandom_range(255, 0));
      load_start = 1'($urandom_range(1, 0));
      load_len   = 11'd1;
      tick;
      chk("t4a_core_held", core_rst_n, 1'b0);
      chk("t4a_err_hold",  load_err,   1'b1);
    end
    load_start = 1'b0;
    in_valid   = 1'b0;
    fetch("t4a_fetch", 64'd0, NOP);

    // Illegal length DEPTH+1
    do_reset;
    chk("t4b_rst_err", load_err, 1'b0);
    start(11'(DEPTH + 1));
    chk("t4b_err",   load_err, 1'b1);
    chk("t4b_ready", in_ready, 1'b0);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick;
      chk("t4b_core_held", core_rst_n, 1'b0);
    end
    in_valid = 1'b0;

    // Reset mid-load, then a one-word load
    do_reset;
    start(11'd4);
    for (int i = 1; i <= 5; i++) send(8'(i));
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", in_ready,   1'b0);
    chk("t5_rst_core",  core_rst_n, 1'b0);
    tick;
    rst = 1'b0;
    tick;
    chk("t5_rst_sum", checksum, 32'h0);
    start(11'd1);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    chk("t5_checksum", checksum, 32'hDDCC_BBAA);
    tick;
    chk("t5_load_done", load_done, 1'b1);
    fetch("t5_mem0",     64'd0, 32'hDDCC_BBAA);
    fetch("t5_mem1_old", 64'd4, 32'h0020_0593);

    // Full-depth load
    do_reset;
    sum_model = 32'h0;
    start(11'(DEPTH));
    for (int k = 0; k < DEPTH; k++) begin
      w = {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};
      sum_model = sum_model + w;
      for (int j = 0; j < 4; j++) send(w[8*j +: 8]);
    end
    chk("full_checksum", checksum, sum_model);
    tick;
    chk("full_load_done", load_done, 1'b1);
    fetch("full_mem1",    64'd4,                 32'h0403_0201);
    fetch("full_memlast", 64'd4 * (DEPTH - 1),   32'h0201_00FF);
    fetch("full_oor",     64'd4 * DEPTH,         NOP);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
